// File: rtl/ad9910_sequencer.sv
// Expands init / single-tone / digital-ramp requests into AD9910 command words, hands each
// to the serial writer over a ready/ndone handshake, then pulses io_update.
module ad9910_sequencer #(
   parameter int unsigned IOUPD_W = 4,
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        init_req_i,
   input  logic        tone_req_i,
   input  logic        ramp_req_i,
   input  logic [31:0] tone_freq_i,
   input  logic [15:0] tone_phase_i,
   input  logic [13:0] tone_amp_i,
   input  logic [31:0] ramp_upper_i,
   input  logic [31:0] ramp_lower_i,
   input  logic [31:0] ramp_dec_i,
   input  logic [31:0] ramp_inc_i,
   input  logic [15:0] ramp_neg_rate_i,
   input  logic [15:0] ramp_pos_rate_i,
   input  logic [4:0]  ramp_cfg_i,
   input  logic        ndone_i,
   output logic [3:0]  dds_cmd_o,
   output logic [63:0] dds_data_o,
   output logic        dds_ready_o,
   output logic        io_update_o,
   output logic        busy_o,
   output logic        seq_done_o,
   output logic        req_drop_o,
   output logic        timeout_err_o,
   output logic        ramp_active_o
);

   localparam int unsigned CntMax = (TIMEOUT > IOUPD_W) ? TIMEOUT : IOUPD_W;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [2:0] {StIdle, StIssue, StAssert, StRelease, StUpdate, StFinish} state_e;
   typedef enum logic [1:0] {KindInit, KindRamp, KindTone} kind_e;

   state_e          state_q;
   kind_e           kind_q;
   logic [1:0]      idx_q;
   logic [CntW-1:0] cnt_q;
   logic [31:0]     freq_q, upper_q, lower_q, dec_q, inc_q;
   logic [15:0]     phase_q, neg_q, pos_q;
   logic [13:0]     amp_q;
   logic [4:0]      cfg_q;
   logic [3:0]      cmd_q;
   logic [63:0]     data_q;
   logic            ready_q, ioupd_q, busy_q, done_q, drop_q, terr_q, ract_q;

   // Tone words are indexed {6:clear-ramp, 7:profile}; a tone without an active ramp
   // simply starts at index 1.
   function automatic logic [67:0] word_f(
      input kind_e k, input logic [1:0] i,
      input logic [31:0] up, input logic [31:0] lo, input logic [31:0] dc, input logic [31:0] ic,
      input logic [15:0] nr, input logic [15:0] pr, input logic [4:0] cfg,
      input logic [31:0] fr, input logic [15:0] ph, input logic [13:0] am);
      logic [67:0] w;
      w = '0;
      case (k)
         KindInit: w = {2'b00, i, 64'h0};
         KindRamp: begin
            case (i)
               2'd0:    w = {4'd5, up, lo};
               2'd1:    w = {4'd3, dc, ic};
               2'd2:    w = {4'd4, 32'h0, nr, pr};
               default: w = {4'd6, 59'h0, cfg};
            endcase
         end
         default: w = (i == 2'd0) ? {4'd6, 64'h0} : {4'd7, 2'b00, am, ph, fr};
      endcase
      return w;
   endfunction

   logic [1:0]  req_cnt;
   logic        any_req, drop_d, last_word, cnt_to;
   kind_e       acc_kind;
   logic [1:0]  acc_idx, nxt_idx;
   logic [67:0] acc_word, nxt_word;

   always_comb begin
      req_cnt  = {1'b0, init_req_i} + {1'b0, ramp_req_i} + {1'b0, tone_req_i};
      any_req  = (req_cnt != 2'd0);
      drop_d   = busy_q ? any_req : (req_cnt > 2'd1);
      acc_kind = init_req_i ? KindInit : (ramp_req_i ? KindRamp : KindTone);
      acc_idx  = (acc_kind == KindTone && !ract_q) ? 2'd1 : 2'd0;
      acc_word = word_f(acc_kind, acc_idx, ramp_upper_i, ramp_lower_i, ramp_dec_i, ramp_inc_i,
                        ramp_neg_rate_i, ramp_pos_rate_i, ramp_cfg_i, tone_freq_i,
                        tone_phase_i, tone_amp_i);
      nxt_idx  = idx_q + 2'd1;
      nxt_word = word_f(kind_q, nxt_idx, upper_q, lower_q, dec_q, inc_q, neg_q, pos_q, cfg_q,
                        freq_q, phase_q, amp_q);
      case (kind_q)
         KindInit: last_word = (idx_q == 2'd2);
         KindRamp: last_word = (idx_q == 2'd3);
         default:  last_word = (idx_q == 2'd1);
      endcase
      cnt_to = (cnt_q == CntW'(TIMEOUT - 1));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         kind_q  <= KindInit;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         freq_q  <= '0;
         upper_q <= '0;
         lower_q <= '0;
         dec_q   <= '0;
         inc_q   <= '0;
         phase_q <= '0;
         neg_q   <= '0;
         pos_q   <= '0;
         amp_q   <= '0;
         cfg_q   <= '0;
         cmd_q   <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ioupd_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
         terr_q  <= 1'b0;
         ract_q  <= 1'b0;
      end else begin
         drop_q <= drop_d;
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (any_req) begin
                  freq_q  <= tone_freq_i;
                  phase_q <= tone_phase_i;
                  amp_q   <= tone_amp_i;
                  upper_q <= ramp_upper_i;
                  lower_q <= ramp_lower_i;
                  dec_q   <= ramp_dec_i;
                  inc_q   <= ramp_inc_i;
                  neg_q   <= ramp_neg_rate_i;
                  pos_q   <= ramp_pos_rate_i;
                  cfg_q   <= ramp_cfg_i;
                  kind_q  <= acc_kind;
                  idx_q   <= acc_idx;
                  {cmd_q, data_q} <= acc_word;
                  terr_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               ready_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= StAssert;
            end
            StAssert: begin
               if (ndone_i) begin
                  ready_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StRelease;
               end else if (cnt_to) begin
                  ready_q <= 1'b0;
                  terr_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StRelease: begin
               if (!ndone_i) begin
                  if (last_word) begin
                     ioupd_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= StUpdate;
                  end else begin
                     idx_q   <= nxt_idx;
                     {cmd_q, data_q} <= nxt_word;
                     state_q <= StIssue;
                  end
               end else if (cnt_to) begin
                  terr_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StUpdate: begin
               if (cnt_q == CntW'(IOUPD_W - 1)) begin
                  ioupd_q <= 1'b0;
                  state_q <= StFinish;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StFinish: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
               if (kind_q == KindRamp) begin
                  ract_q <= cfg_q[2];
               end else if (kind_q == KindTone) begin
                  ract_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dds_cmd_o     = cmd_q;
   assign dds_data_o    = data_q;
   assign dds_ready_o   = ready_q;
   assign io_update_o   = ioupd_q;
   assign busy_o        = busy_q;
   assign seq_done_o    = done_q;
   assign req_drop_o    = drop_q;
   assign timeout_err_o = terr_q;
   assign ramp_active_o = ract_q;

endmodule
